// File: rtl/seg_pkg.sv
// Shared constants for the seconds display path.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [3:0] AN_OFF    = 4'b1111;
   localparam logic [7:0] BCD_MARK  = 8'hFF;

   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   typedef enum logic [1:0] {
      CV_IDLE  = 2'd0,
      CV_SHIFT = 2'd1,
      CV_DONE  = 2'd2
   } cv_state_e;

   // Only the over-range marker produces nibble F; other non-digits go dark.
   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      logic [7:0] s;
      s = SEG_BLANK;
      if (nib <= 4'd9) begin
         s = SEG_DIGIT[nib];
      end else if (nib == 4'hF) begin
         s = SEG_DASH;
      end
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, restarts whenever the input
// differs from the last value it converted.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int MAX_VALUE = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] value,
   output logic [7:0] bcd,
   output logic       busy
);

   localparam logic [6:0] MAXV = 7'(MAX_VALUE);

   cv_state_e   state_q, state_d;
   logic [14:0] sr_q, sr_d;
   logic [6:0]  last_q, last_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  bcd_q, bcd_d;
   logic [14:0] adj;
   logic        change;

   assign change = (value != last_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= CV_IDLE;
         sr_q    <= '0;
         last_q  <= '0;
         cnt_q   <= '0;
         bcd_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   always_comb begin
      adj = sr_q;
      if (sr_q[10:7] >= 4'd5) begin
         adj[10:7] = sr_q[10:7] + 4'd3;
      end
      if (sr_q[14:11] >= 4'd5) begin
         adj[14:11] = sr_q[14:11] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      unique case (state_q)
         CV_IDLE: begin
            if (change) begin
               sr_d    = {8'h00, value};
               last_d  = value;
               cnt_d   = '0;
               state_d = CV_SHIFT;
            end
         end
         CV_SHIFT: begin
            sr_d  = {adj[13:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
               state_d = CV_DONE;
            end
         end
         CV_DONE: begin
            bcd_d   = (last_q > MAXV) ? BCD_MARK : sr_q[14:7];
            state_d = CV_IDLE;
         end
         default: begin
            state_d = CV_IDLE;
         end
      endcase
   end

   // A pending change counts as busy so the flag spans load..done.
   always_comb begin
      busy = reset && ((state_q != CV_IDLE) || change);
      bcd  = bcd_q;
   end

endmodule

// File: rtl/seg_scan_display.sv
// Two-digit multiplexed 7-segment driver for the seconds counter,
// with frame-aligned digit snapshots and pause blinking.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 50,
   parameter int MAX_VALUE   = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] value,
   input  logic       power,
   output logic [3:0] an,
   output logic [7:0] seg,
   output logic       busy
);

   localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SLOT_TC = SW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] FRM_TC  = FW'(BLINK_DIV - 1);

   logic [SW-1:0] slot_q, slot_d;
   logic [FW-1:0] frm_q, frm_d;
   logic [1:0]    idx_q, idx_d;
   logic [7:0]    snap_q, snap_d;
   logic          blink_q, blink_d;
   logic [3:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;
   logic [7:0]    bcd;
   logic          slot_tc;
   logic          frame_tc;

   bin2bcd_seq #(
      .MAX_VALUE (MAX_VALUE)
   ) u_conv (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .bcd   (bcd),
      .busy  (busy)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q  <= '0;
         frm_q   <= '0;
         idx_q   <= 2'd0;
         snap_q  <= 8'h00;
         blink_q <= 1'b1;
         an_q    <= AN_OFF;
         seg_q   <= SEG_BLANK;
      end else begin
         slot_q  <= slot_d;
         frm_q   <= frm_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         blink_q <= blink_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign slot_tc  = (slot_q == SLOT_TC);
   assign frame_tc = slot_tc && (idx_q == 2'd3);

   // Snapshot only on the 3->0 wrap so a frame never mixes digits.
   always_comb begin
      slot_d  = slot_tc ? '0 : slot_q + SW'(1);
      idx_d   = slot_tc ? idx_q + 2'd1 : idx_q;
      snap_d  = frame_tc ? bcd : snap_q;
      frm_d   = frm_q;
      blink_d = blink_q;
      if (power) begin
         frm_d   = '0;
         blink_d = 1'b1;
      end else if (frame_tc) begin
         if (frm_q == FRM_TC) begin
            frm_d   = '0;
            blink_d = !blink_q;
         end else begin
            frm_d = frm_q + FW'(1);
         end
      end
   end

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      if (blink_q) begin
         unique case (idx_q)
            2'd0: begin
               an_d  = ~(4'b0001 << idx_q);
               seg_d = seg_decode(snap_q[3:0]);
            end
            2'd1: begin
               an_d  = ~(4'b0001 << idx_q);
               seg_d = (snap_q[7:4] == 4'd0) ? SEG_BLANK
                                             : seg_decode(snap_q[7:4]);
            end
            default: begin
               an_d  = AN_OFF;
               seg_d = SEG_BLANK;
            end
         endcase
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with short refresh/blink dividers.
// Frame = 4 slots x 4 clks = 16 clks.
module tb_seg_scan_display;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       power = 1'b1;
   logic [6:0] value = 7'd0;
   logic [3:0] an;
   logic [7:0] seg;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nbusy;

   seg_scan_display #(
      .REFRESH_DIV (4),
      .BLINK_DIV   (2),
      .MAX_VALUE   (99)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .value (value),
      .power (power),
      .an    (an),
      .seg   (seg),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((cyc % 16 != 0) && (n < 40));
      check("frame_sync", (cyc % 16 == 0), 1);
   endtask

   task automatic chk_frame(input string tag, input logic on,
                            input logic [7:0] ones, input logic [7:0] tens);
      logic [3:0] one;
      logic [3:0] ea;
      logic [7:0] es;
      one = 4'b0001;
      for (int s = 0; s < 4; s++) begin
         repeat (2) @(posedge clk);
         @(negedge clk);
         ea = (on && s < 2) ? ~(one << s) : 4'b1111;
         es = !on ? 8'hFF : (s == 0) ? ones : (s == 1) ? tens : 8'hFF;
         check($sformatf("%s.an%0d", tag, s), an, ea);
         check($sformatf("%s.seg%0d", tag, s), seg, es);
         repeat (2) @(posedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b0;
      #1;
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 8'hFF);
      check("rst_busy", busy, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      chk_frame("t1a", 1, 8'hC0, 8'hFF);

      // 37: busy spans load + 7 shifts + done
      @(negedge clk);
      value = 7'd37;
      nbusy = 0;
      #1 if (busy) nbusy++;
      repeat (11) begin
         @(negedge clk);
         if (busy) nbusy++;
      end
      check("t2_busy_len", nbusy, 9);
      repeat (10) @(posedge clk);
      wait_frame();
      chk_frame("t2", 1, 8'hF8, 8'hB0);

      @(negedge clk);
      value = 7'd5;
      repeat (10) @(posedge clk);
      wait_frame();
      chk_frame("t3", 1, 8'h92, 8'hFF);

      // reset mid-frame clears snapshot; value 0 needs no conversion
      wait_frame();
      repeat (6) @(posedge clk);
      #2 reset = 1'b0;
      value = 7'd0;
      #1;
      check("t1b_an", an, 4'b1111);
      check("t1b_seg", seg, 8'hFF);
      check("t1b_busy", busy, 0);
      @(negedge clk);
      reset = 1'b1;
      chk_frame("t1b", 1, 8'hC0, 8'hFF);

      @(negedge clk);
      value = 7'd39;
      repeat (10) @(posedge clk);
      wait_frame();
      chk_frame("t4a", 1, 8'h90, 8'hB0);
      wait_frame();
      value = 7'd0;
      chk_frame("t4b", 1, 8'h90, 8'hB0);
      chk_frame("t4c", 1, 8'hC0, 8'hFF);

      @(negedge clk);
      value = 7'd12;
      repeat (10) @(posedge clk);
      wait_frame();
      chk_frame("t5_run", 1, 8'hA4, 8'hF9);
      wait_frame();
      power = 1'b0;
      chk_frame("t5_f0", 1, 8'hA4, 8'hF9);
      chk_frame("t5_f1", 1, 8'hA4, 8'hF9);
      chk_frame("t5_f2", 0, 8'hA4, 8'hF9);
      chk_frame("t5_f3", 0, 8'hA4, 8'hF9);
      chk_frame("t5_f4", 1, 8'hA4, 8'hF9);
      chk_frame("t5_f5", 1, 8'hA4, 8'hF9);
      wait_frame();
      power = 1'b1;
      chk_frame("t5_resume", 1, 8'hA4, 8'hF9);
      chk_frame("t5_steady", 1, 8'hA4, 8'hF9);

      @(negedge clk);
      value = 7'd100;
      repeat (10) @(posedge clk);
      wait_frame();
      chk_frame("t6_over", 1, 8'hBF, 8'hBF);
      @(negedge clk);
      value = 7'd20;
      @(negedge clk);
      value = 7'd21;
      @(negedge clk);
      value = 7'd22;
      check("t6_busy_mid", busy, 1);
      repeat (25) @(posedge clk);
      @(negedge clk);
      check("t6_busy_end", busy, 0);
      wait_frame();
      chk_frame("t6_final", 1, 8'hA4, 8'hA4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
